// File: rtl/p3_shared_ram_arbiter.sv
// p3_shared_ram_arbiter: round-robin arbiter sharing one synchronous RAM among NUM_CORES cores, with read return and done aggregation
module p3_shared_ram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           RAM_ADDRESS,
  output logic [DATA_W-1:0]           DATA_BUS_out,
  input  logic [DATA_W-1:0]           DATA_BUS_in,
  output logic                        M_Write,
  output logic                        RAM_en,
  output logic                        End_of_process
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  logic [PW-1:0]        ptr, win, idx;
  logic                 found;
  logic [NUM_CORES-1:0] done_seen, elig;
  logic [RD_LAT:0]      pv;
  logic [PW-1:0]        pc [RD_LAT+1];
  assign elig = core_req & ~done_seen;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int o = NUM_CORES - 1; o >= 0; o--) begin
      idx = PW'((int'(ptr) + o) % NUM_CORES);
      if (elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign core_gnt = found ? (NUM_CORES'(1) << win) : '0;
  // pv/pc form the read-return pipeline: pv[j] marks a read, pc[j] its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RAM_en <= 1'b0;
      M_Write <= 1'b0;
      RAM_ADDRESS <= '0;
      DATA_BUS_out <= '0;
      core_rvalid <= '0;
      core_rdata <= '0;
      End_of_process <= 1'b0;
      ptr <= '0;
      done_seen <= '0;
      pv <= '0;
      for (int j = 0; j <= RD_LAT; j++) pc[j] <= '0;
    end else begin
      RAM_en <= found;
      M_Write <= found & core_we[win];
      if (found) begin
        RAM_ADDRESS <= core_addr[win*ADDR_W +: ADDR_W];
        DATA_BUS_out <= core_wdata[win*DATA_W +: DATA_W];
      end
      ptr <= start ? '0 : found ? ((win == PW'(NUM_CORES - 1)) ? '0 : win + 1'b1) : ptr;
      done_seen <= start ? '0 : done_seen | core_done;
      End_of_process <= start ? 1'b0 : End_of_process | (&done_seen & ~|pv);
      pv <= {pv[RD_LAT-1:0], found & ~core_we[win]};
      pc[0] <= win;
      for (int j = 1; j <= RD_LAT; j++) pc[j] <= pc[j-1];
      core_rvalid <= pv[RD_LAT] ? (NUM_CORES'(1) << pc[RD_LAT]) : '0;
      if (pv[RD_LAT]) core_rdata <= DATA_BUS_in;
    end
  end
endmodule
